// File: rtl/gmii_rx_fcs_filter.sv
// gmii_rx_fcs_filter
//   Store-and-forward GMII receive filter. Each incoming frame (preamble
//   included) is written into a circular byte buffer while its SFD, length
//   and FCS are checked. Good frames are committed and their total length is
//   queued. Bad frames are rewound away. A reader replays committed frames
//   byte-for-byte with a minimum inter-frame gap.
// Ports
//   clk, rst_n            : 125 MHz clock, async active-low reset
//   in_rx_dv, in_rxd      : raw GMII receive stream
//   out_rx_dv, out_rxd    : filtered GMII stream (out_rxd = 0 when idle)
//   frame_good, frame_bad : 1-cycle commit / drop pulses
//   good_cnt, drop_cnt    : saturating frame counters
module gmii_rx_fcs_filter #(
  parameter int BUF_AW    = 11,
  parameter int LEN_DEPTH = 8,   // power of two
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 1522,
  parameter int IFG       = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_rx_dv,
  input  logic [7:0]  in_rxd,
  output logic        out_rx_dv,
  output logic [7:0]  out_rxd,
  output logic        frame_good,
  output logic        frame_bad,
  output logic [15:0] good_cnt,
  output logic [15:0] drop_cnt
);
  localparam int LAW = (LEN_DEPTH > 1) ? $clog2(LEN_DEPTH) : 1;
  localparam int IW  = (IFG > 1) ? $clog2(IFG) : 1;
  localparam logic [15:0]       MIN_L   = 16'(MIN_LEN);
  localparam logic [15:0]       MAX_L   = 16'(MAX_LEN);
  localparam logic [31:0]       RESIDUE = 32'hDEBB20E3;
  localparam logic [BUF_AW-1:0] ONE     = 1;

  typedef enum logic [1:0] {W_IDLE, W_PRE, W_DATA, W_DROP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_SEND, R_IFG} rstate_e;

  // Reflected CRC-32 over one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  logic [7:0]        mem [2**BUF_AW];
  logic [15:0]       len_mem [LEN_DEPTH];

  wstate_e           ws_q, ws_d;
  logic [BUF_AW-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d;
  logic [31:0]       crc_q, crc_d;
  logic [15:0]       dcnt_q, dcnt_d, flen_q, flen_d;
  logic              drop_pend_q, drop_pend_d, dv_prev_q;
  logic              mem_we, push, pop, ovf, len_full;
  logic [LAW-1:0]    lwr_q, lwr_d, lrd_q, lrd_d;
  logic [LAW:0]      lcnt_q, lcnt_d;

  rstate_e           rs_q, rs_d;
  logic [BUF_AW-1:0] rd_ptr_q, rd_ptr_d, rd_base_q, rd_base_d, rd_addr;
  logic [15:0]       rcnt_q, rcnt_d;
  logic [IW-1:0]     ifg_q, ifg_d;
  logic [7:0]        ram_q;
  logic              out_rx_dv_q, out_rx_dv_d;
  logic [7:0]        out_rxd_q, out_rxd_d;
  logic              frame_good_q, frame_good_d, frame_bad_q, frame_bad_d;
  logic [15:0]       good_cnt_q, good_cnt_d, drop_cnt_q, drop_cnt_d;

  // Buffer is full when the next write would land on the oldest unreplayed byte.
  assign ovf      = (wr_ptr_q + ONE) == rd_base_q;
  assign len_full = lcnt_q == (LAW+1)'(LEN_DEPTH);

  // Writer
  always_comb begin
    ws_d = ws_q; wr_ptr_d = wr_ptr_q; commit_ptr_d = commit_ptr_q;
    crc_d = crc_q; dcnt_d = dcnt_q; flen_d = flen_q; drop_pend_d = drop_pend_q;
    mem_we = 1'b0; push = 1'b0; frame_good_d = 1'b0; frame_bad_d = 1'b0;
    case (ws_q)
      W_IDLE: if (in_rx_dv) begin
        // dv already high (e.g. straight out of reset): tail of an unseen frame, ignore silently.
        if (dv_prev_q)  begin ws_d = W_DROP; drop_pend_d = 1'b0; end
        else if (ovf)   begin ws_d = W_DROP; drop_pend_d = 1'b1; end
        else begin
          mem_we = 1'b1; wr_ptr_d = wr_ptr_q + ONE; flen_d = 16'd1; ws_d = W_PRE;
        end
      end
      W_PRE: begin
        if (!in_rx_dv) begin
          frame_bad_d = 1'b1; wr_ptr_d = commit_ptr_q; ws_d = W_IDLE;
        end else if (ovf) begin
          ws_d = W_DROP; drop_pend_d = 1'b1;
        end else begin
          mem_we = 1'b1; wr_ptr_d = wr_ptr_q + ONE; flen_d = flen_q + 16'd1;
          if (in_rxd == 8'hD5) begin
            ws_d = W_DATA; crc_d = '1; dcnt_d = '0;
          end else if (flen_q >= 16'd7) begin  // 8th byte and still no SFD
            ws_d = W_DROP; drop_pend_d = 1'b1;
          end
        end
      end
      W_DATA: begin
        if (!in_rx_dv) begin
          if (crc_q == RESIDUE && dcnt_q >= MIN_L && dcnt_q <= MAX_L && !len_full) begin
            commit_ptr_d = wr_ptr_q; push = 1'b1; frame_good_d = 1'b1;
          end else begin
            wr_ptr_d = commit_ptr_q; frame_bad_d = 1'b1;
          end
          ws_d = W_IDLE;
        end else if (ovf || dcnt_q >= MAX_L) begin
          ws_d = W_DROP; drop_pend_d = 1'b1;
        end else begin
          mem_we = 1'b1; wr_ptr_d = wr_ptr_q + ONE; flen_d = flen_q + 16'd1;
          dcnt_d = dcnt_q + 16'd1; crc_d = crc_byte(crc_q, in_rxd);
        end
      end
      default: begin  // W_DROP
        if (!in_rx_dv) begin
          ws_d = W_IDLE; drop_pend_d = 1'b0;
          if (drop_pend_q) begin frame_bad_d = 1'b1; wr_ptr_d = commit_ptr_q; end
        end
      end
    endcase
  end

  // Reader: ram_q is a registered read, so the address is always one byte ahead.
  always_comb begin
    rs_d = rs_q; rd_ptr_d = rd_ptr_q; rd_base_d = rd_base_q; rcnt_d = rcnt_q; ifg_d = ifg_q;
    rd_addr = rd_ptr_q; pop = 1'b0; out_rx_dv_d = 1'b0; out_rxd_d = 8'h00;
    case (rs_q)
      R_IDLE: if (lcnt_q != '0) begin
        pop = 1'b1; rd_addr = rd_base_q; rd_ptr_d = rd_base_q + ONE;
        rcnt_d = len_mem[lrd_q]; rs_d = R_SEND;
      end
      R_SEND: begin
        out_rx_dv_d = 1'b1; out_rxd_d = ram_q;
        rd_ptr_d = rd_ptr_q + ONE; rcnt_d = rcnt_q - 16'd1;
        if (rcnt_q == 16'd1) begin
          // rd_ptr_q is now base + L: release the replayed frame.
          rd_base_d = rd_ptr_q; ifg_d = IW'(IFG - 1); rs_d = R_IFG;
        end
      end
      default: begin  // R_IFG
        if (ifg_q == '0) rs_d = R_IDLE;
        else             ifg_d = ifg_q - IW'(1);
      end
    endcase
  end

  always_comb begin
    lwr_d = push ? lwr_q + LAW'(1) : lwr_q;
    lrd_d = pop  ? lrd_q + LAW'(1) : lrd_q;
    lcnt_d = lcnt_q;
    case ({push, pop})
      2'b10:   lcnt_d = lcnt_q + (LAW+1)'(1);
      2'b01:   lcnt_d = lcnt_q - (LAW+1)'(1);
      default: lcnt_d = lcnt_q;
    endcase
    good_cnt_d = (frame_good_d && good_cnt_q != 16'hFFFF) ? good_cnt_q + 16'd1 : good_cnt_q;
    drop_cnt_d = (frame_bad_d  && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= in_rxd;
    if (push)   len_mem[lwr_q] <= flen_q;
    ram_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_q <= W_IDLE; wr_ptr_q <= '0; commit_ptr_q <= '0; crc_q <= '1;
      dcnt_q <= '0; flen_q <= '0; drop_pend_q <= 1'b0; dv_prev_q <= 1'b1;
      lwr_q <= '0; lrd_q <= '0; lcnt_q <= '0;
      rs_q <= R_IDLE; rd_ptr_q <= '0; rd_base_q <= '0; rcnt_q <= '0; ifg_q <= '0;
      out_rx_dv_q <= 1'b0; out_rxd_q <= '0; frame_good_q <= 1'b0; frame_bad_q <= 1'b0;
      good_cnt_q <= '0; drop_cnt_q <= '0;
    end else begin
      ws_q <= ws_d; wr_ptr_q <= wr_ptr_d; commit_ptr_q <= commit_ptr_d; crc_q <= crc_d;
      dcnt_q <= dcnt_d; flen_q <= flen_d; drop_pend_q <= drop_pend_d; dv_prev_q <= in_rx_dv;
      lwr_q <= lwr_d; lrd_q <= lrd_d; lcnt_q <= lcnt_d;
      rs_q <= rs_d; rd_ptr_q <= rd_ptr_d; rd_base_q <= rd_base_d; rcnt_q <= rcnt_d; ifg_q <= ifg_d;
      out_rx_dv_q <= out_rx_dv_d; out_rxd_q <= out_rxd_d;
      frame_good_q <= frame_good_d; frame_bad_q <= frame_bad_d;
      good_cnt_q <= good_cnt_d; drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_rx_dv  = out_rx_dv_q;
  assign out_rxd    = out_rxd_q;
  assign frame_good = frame_good_q;
  assign frame_bad  = frame_bad_q;
  assign good_cnt   = good_cnt_q;
  assign drop_cnt   = drop_cnt_q;
endmodule
